// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: AND/OR/ADD/SUB/SLT with a combinational result and
// registered status copies for trace.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] AluOp1,
  input  logic [WIDTH-1:0] AluOp2,
  input  logic [2:0]       AluCtrl,
  output logic [WIDTH-1:0] AluResult,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] AluResultQ,
  output logic             ZeroQ,
  output logic             OverflowQ
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt;

  logic is_and;
  logic is_or;
  logic is_add;
  logic is_sub;
  logic is_slt;

  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             zero_d;

  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic             zero_q;

  assign sum  = AluOp1 + AluOp2;
  assign diff = AluOp1 + ~AluOp2 + {{(WIDTH-1){1'b0}}, 1'b1};

  assign ovf_add = (AluOp1[MSB] == AluOp2[MSB])
                && (sum[MSB] != AluOp1[MSB]);
  assign ovf_sub = (AluOp1[MSB] != AluOp2[MSB])
                && (diff[MSB] != AluOp1[MSB]);

  // Sign of the difference is wrong exactly when the subtract overflows.
  assign lt = diff[MSB] ^ ovf_sub;

  assign is_and = (AluCtrl == 3'b000);
  assign is_or  = (AluCtrl == 3'b001);
  assign is_add = (AluCtrl == 3'b010);
  assign is_sub = (AluCtrl == 3'b110);
  assign is_slt = (AluCtrl == 3'b111);

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unique case (1'b1)
      is_and: res_d = AluOp1 & AluOp2;
      is_or:  res_d = AluOp1 | AluOp2;
      is_add: begin
        res_d = sum;
        ovf_d = ovf_add;
      end
      is_sub: begin
        res_d = diff;
        ovf_d = ovf_sub;
      end
      is_slt: res_d = {{(WIDTH-1){1'b0}}, lt};
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  assign zero_d = ~|res_d;

  assign AluResult = res_d;
  assign Zero      = zero_d;
  assign Overflow  = ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign AluResultQ = res_q;
  assign ZeroQ      = zero_q;
  assign OverflowQ  = ovf_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed and random checks for mips_alu.
// Combinational outputs are sampled #1 after driving; registers #1 after posedge.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ctrl;
  logic [31:0] res;
  logic        zero;
  logic        ovf;
  logic [31:0] res_q;
  logic        zero_q;
  logic        ovf_q;

  int total;
  int bad;

  mips_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AluOp1     (a),
    .AluOp2     (b),
    .AluCtrl    (ctrl),
    .AluResult  (res),
    .Zero       (zero),
    .Overflow   (ovf),
    .AluResultQ (res_q),
    .ZeroQ      (zero_q),
    .OverflowQ  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'h0;
    b = 32'h0;
    ctrl = 3'b000;
    #12;
    total++;
    if (res_q !== 32'h0 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
      bad++;
      $display("FAIL reset_q got=%h/%b/%b want=0/0/0", res_q, zero_q, ovf_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h1; ctrl = 3'b010;
    #1;
    total++;
    if (res !== 32'h8000_0000 || zero !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL add_ovf got=%h/%b/%b want=80000000/0/1", res, zero, ovf);
    end
    @(posedge clk); #1;
    total++;
    if (res_q !== 32'h8000_0000 || zero_q !== 1'b0 || ovf_q !== 1'b1) begin
      bad++;
      $display("FAIL add_ovf_q got=%h/%b/%b want=80000000/0/1", res_q, zero_q, ovf_q);
    end
    @(negedge clk);
    a = 32'd5; b = 32'd3;
    #1;
    total++;
    if (res !== 32'd8 || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_5_3 got=%h/%b/%b want=8/0/0", res, zero, ovf);
    end
    a = 32'hFFFF_FFFF; b = 32'h1;
    #1;
    total++;
    if (res !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_wrap got=%h/%b/%b want=0/1/0", res, zero, ovf);
    end
    a = 32'h8000_0000; b = 32'h8000_0000;
    #1;
    total++;
    if (res !== 32'h0 || zero !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL add_negovf got=%h/%b/%b want=0/1/1", res, zero, ovf);
    end
  endtask

  task automatic test_sub();
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; ctrl = 3'b110;
    #1;
    total++;
    if (res !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_eq got=%h/%b/%b want=0/1/0", res, zero, ovf);
    end
    a = 32'h0; b = 32'h1;
    #1;
    total++;
    if (res !== 32'hFFFF_FFFF || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_0_1 got=%h/%b/%b want=ffffffff/0/0", res, zero, ovf);
    end
    a = 32'h8000_0000; b = 32'h1;
    #1;
    total++;
    if (res !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf got=%h/%b want=7fffffff/1", res, ovf);
    end
    a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF;
    #1;
    total++;
    if (res !== 32'h8000_0000 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf2 got=%h/%b want=80000000/1", res, ovf);
    end
  endtask

  task automatic test_slt();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1;         vr[0] = 32'd1;
    va[1] = 32'h1;         vb[1] = 32'hFFFF_FFFF; vr[1] = 32'd0;
    va[2] = 32'h8000_0000; vb[2] = 32'h7FFF_FFFF; vr[2] = 32'd1;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h8000_0000; vr[3] = 32'd0;
    va[4] = 32'h0000_0042; vb[4] = 32'h0000_0042; vr[4] = 32'd0;
    @(negedge clk);
    ctrl = 3'b111;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i];
      #1;
      total++;
      if (res !== vr[i] || zero !== (vr[i] == 32'd0) || ovf !== 1'b0) begin
        bad++;
        $display("FAIL slt_%0d got=%h/%b/%b want=%h", i, res, zero, ovf, vr[i]);
      end
    end
  endtask

  task automatic test_logic();
    @(negedge clk);
    a = 32'hF0F0_00FF; b = 32'h0FF0_0F0F; ctrl = 3'b000;
    #1;
    total++;
    if (res !== 32'h00F0_000F || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL and got=%h/%b/%b want=00f0000f/0/0", res, zero, ovf);
    end
    ctrl = 3'b001;
    #1;
    total++;
    if (res !== 32'hFFF0_0FFF || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL or got=%h/%b/%b want=fff00fff/0/0", res, zero, ovf);
    end
  endtask

  task automatic test_default();
    logic [2:0] codes [3];
    codes[0] = 3'b011; codes[1] = 3'b100; codes[2] = 3'b101;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ctrl = codes[i];
      a = 32'h7FFF_FFFF;
      b = 32'h7FFF_FFFF;
      #1;
      total++;
      if (res !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL dflt_%b got=%h/%b/%b want=0/1/0", codes[i], res, zero, ovf);
      end
    end
  endtask

  task automatic test_regs();
    @(negedge clk);
    a = 32'd5; b = 32'd3; ctrl = 3'b010;
    @(posedge clk); #1;
    total++;
    if (res_q !== 32'd8 || zero_q !== 1'b0 || ovf_q !== 1'b0) begin
      bad++;
      $display("FAIL regs_load got=%h/%b/%b want=8/0/0", res_q, zero_q, ovf_q);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (res_q !== 32'h0 || zero_q !== 1'b0 || ovf_q !== 1'b0 || res !== 32'd8) begin
      bad++;
      $display("FAIL regs_async_rst got=%h/%b/%b live=%h want=0/0/0 live=8",
               res_q, zero_q, ovf_q, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (res_q !== 32'd8 || zero_q !== 1'b0) begin
      bad++;
      $display("FAIL regs_release got=%h/%b want=8/0", res_q, zero_q);
    end
    @(negedge clk);
    a = 32'd9; b = 32'd9; ctrl = 3'b110;
    @(posedge clk); #1;
    total++;
    if (res_q !== 32'h0 || zero_q !== 1'b1) begin
      bad++;
      $display("FAIL regs_zeroq got=%h/%b want=0/1", res_q, zero_q);
    end
  endtask

  task automatic test_random();
    logic [31:0] er;
    logic        eo;
    longint      sa;
    longint      sb;
    longint      s;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a = $urandom();
      b = $urandom();
      if (i % 6 == 0) b = a;
      if (i % 6 == 1) a = {a[31], 31'h7FFF_FFFF};
      ctrl = 3'($urandom_range(0, 7));
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      er = 32'h0;
      eo = 1'b0;
      case (ctrl)
        3'b000: er = a & b;
        3'b001: er = a | b;
        3'b010: begin
          s = sa + sb;
          er = s[31:0];
          eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        3'b110: begin
          s = sa - sb;
          er = s[31:0];
          eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        3'b111: er = (sa < sb) ? 32'd1 : 32'd0;
        default: er = 32'h0;
      endcase
      #1;
      total++;
      if (res !== er || zero !== (er == 32'h0) || ovf !== eo) begin
        bad++;
        $display("FAIL rand_%0d ctrl=%b a=%h b=%h got=%h/%b/%b want=%h/%b/%b",
                 i, ctrl, a, b, res, zero, ovf, er, (er == 32'h0), eo);
      end
      @(posedge clk); #1;
      total++;
      if (res_q !== er || zero_q !== (er == 32'h0) || ovf_q !== eo) begin
        bad++;
        $display("FAIL rand_q_%0d got=%h/%b/%b want=%h/%b/%b",
                 i, res_q, zero_q, ovf_q, er, (er == 32'h0), eo);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_default();
    test_regs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
